// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART receiver.
// The receiver FSM states, parity mode encodings and baud divisor limits live here.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;
   localparam logic [1:0] PAR_RSVD = 2'b11;

   localparam int unsigned DIV_MIN     = 4;
   localparam int unsigned DEFAULT_DIV = 32'h1869;

   function automatic logic parity_enabled(input logic [1:0] mode);
      logic en;
      case (mode)
         PAR_EVEN, PAR_ODD:  en = 1'b1;
         PAR_NONE, PAR_RSVD: en = 1'b0;
         default:            en = 1'b0;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side port of the receive FIFO: the memory controller pops bytes here.
// The controller is the master (drives rd_en); the receiver is the slave.
interface uart_rx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                 rd_en;
   logic [DATA_BITS-1:0] data_received;
   logic                 uart_inbound;
   logic                 empty;
   logic                 full;
   logic [CW-1:0]        count;

   modport master (
      output rd_en,
      input  data_received, uart_inbound, empty, full, count
   );

   modport slave (
      input  rd_en,
      output data_received, uart_inbound, empty, full, count
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head reads 0 while empty.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   accepted
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign pop_ok   = pop && !empty;
   assign accepted = push && (!full || pop_ok);
   assign head     = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (accepted) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accepted) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)   rd_ptr <= rd_ptr + AW'(1);
         if (accepted && !pop_ok)      count <= count + CW'(1);
         else if (!accepted && pop_ok) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Asynchronous serial receiver with runtime parity, programmable baud divisor,
// sticky error flags and a FWFT receive FIFO towards the memory controller.
//
// state     | meaning
// IDLE      | line idle, waiting for a synchronised falling edge
// START     | half a bit in, confirming the start bit (high = false start)
// DATA      | sampling DATA_BITS data bits, LSB first, one per divisor period
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit; pushes the byte or flags a framing error
// WAIT_HIGH | line held low after a bad stop bit (break); wait for idle level
module uart_rx_fifo #(
   parameter int          DATA_BITS   = 8,
   parameter int          DIV_W       = 13,
   parameter int unsigned DEFAULT_DIV = uart_pkg::DEFAULT_DIV,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx,
   input  logic [DIV_W-1:0] speed,
   input  logic             set_speed,
   input  logic [1:0]       parity_mode,
   input  logic             clear_err,
   uart_rx_fifo_if.slave    host,
   output logic             frame_err,
   output logic             parity_err,
   output logic             overrun_err
);
   import uart_pkg::*;

   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   logic                 rx_s1, rx_s2, rx_s3;
   logic                 rx_fall;
   logic [DIV_W-1:0]     div_pending, div_active, div_clamped, cnt;
   logic                 tick;
   logic [IW-1:0]        bit_idx;
   logic                 last_bit;
   logic [DATA_BITS-1:0] shreg;
   logic [1:0]           par_mode_q;
   logic                 par_on, par_expect, par_bad;
   state_t               state, state_nx;

   logic start_frame, in_frame, data_sample, par_sample, stop_sample;
   logic push_req, frame_set, parity_set, overrun_set, fifo_accepted;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) {rx_s1, rx_s2, rx_s3} <= 3'b111;
      else        {rx_s1, rx_s2, rx_s3} <= {rx, rx_s1, rx_s2};
   end

   assign rx_fall     = rx_s3 && !rx_s2;
   assign div_clamped = (div_pending < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_pending;
   assign tick        = (cnt == '0);
   assign last_bit    = (bit_idx == IW'(DATA_BITS - 1));
   assign par_on      = parity_enabled(par_mode_q);
   assign par_expect  = (par_mode_q == PAR_ODD) ? ~^shreg : ^shreg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (rx_fall)           state_nx = START;
         START:     if (tick)              state_nx = rx_s2 ? IDLE : DATA;
         DATA:      if (tick && last_bit)  state_nx = par_on ? PARITY : STOP;
         PARITY:    if (tick)              state_nx = STOP;
         STOP:      if (tick)              state_nx = rx_s2 ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rx_s2)             state_nx = IDLE;
         default:                          state_nx = IDLE;
      endcase
   end

   always_comb begin
      start_frame = (state == IDLE) && rx_fall;
      in_frame    = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
      data_sample = (state == DATA) && tick;
      par_sample  = (state == PARITY) && tick;
      stop_sample = (state == STOP) && tick;
      push_req    = stop_sample && rx_s2;
      frame_set   = stop_sample && !rx_s2;
      parity_set  = push_req && par_bad;
      overrun_set = push_req && host.full && !host.rd_en;
   end

   // The pending divisor only becomes active at a frame start so a mid-frame change is harmless.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_pending <= DIV_W'(DEFAULT_DIV);
         div_active  <= DIV_W'(DEFAULT_DIV);
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         par_mode_q  <= PAR_NONE;
         par_bad     <= 1'b0;
      end else begin
         if (set_speed) div_pending <= speed;
         if (start_frame) begin
            div_active <= div_clamped;
            cnt        <= div_clamped >> 1;
            par_mode_q <= parity_mode;
            bit_idx    <= '0;
            par_bad    <= 1'b0;
         end else if (in_frame) begin
            cnt <= tick ? div_active - DIV_W'(1) : cnt - DIV_W'(1);
         end
         if (data_sample) begin
            shreg   <= {rx_s2, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IW'(1);
         end
         if (par_sample) par_bad <= (rx_s2 != par_expect);
      end
   end

   // A same-cycle error set beats clear_err.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_err         <= 1'b0;
         parity_err        <= 1'b0;
         overrun_err       <= 1'b0;
         host.uart_inbound <= 1'b0;
      end else begin
         host.uart_inbound <= fifo_accepted;
         if (frame_set)        frame_err   <= 1'b1;
         else if (clear_err)   frame_err   <= 1'b0;
         if (parity_set)       parity_err  <= 1'b1;
         else if (clear_err)   parity_err  <= 1'b0;
         if (overrun_set)      overrun_err <= 1'b1;
         else if (clear_err)   overrun_err <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_req),
      .wdata    (shreg),
      .pop      (host.rd_en),
      .head     (host.data_received),
      .empty    (host.empty),
      .full     (host.full),
      .count    (host.count),
      .accepted (fifo_accepted)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames are driven bit by bit and a queue model
// of received bytes and sticky flags is compared against the FIFO port while the line is quiet.
module tb_uart_rx_fifo;
   localparam int DB    = 8;
   localparam int DW    = 13;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          rx;
   logic [DW-1:0] speed;
   logic          set_speed;
   logic [1:0]    parity_mode;
   logic          clear_err;
   logic          frame_err, parity_err, overrun_err;

   uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(
      .DATA_BITS   (DB),
      .DIV_W       (DW),
      .DEFAULT_DIV (32'h1869),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .speed       (speed),
      .set_speed   (set_speed),
      .parity_mode (parity_mode),
      .clear_err   (clear_err),
      .host        (bus),
      .frame_err   (frame_err),
      .parity_err  (parity_err),
      .overrun_err (overrun_err)
   );

   always #5 clk = ~clk;

   // model state
   logic [7:0] q[$];
   logic       m_frame, m_par, m_ovr;
   int         m_pushes = 0;
   int         inb_cnt  = 0;
   bit         chk_en   = 1'b0;
   int         tests    = 0;
   int         fails    = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (bus.uart_inbound === 1'b1) inb_cnt++;
      if (chk_en) begin
         check("cyc_head",    32'(bus.data_received), (q.size() > 0) ? 32'(q[0]) : 32'd0);
         check("cyc_count",   32'(bus.count),         32'(q.size()));
         check("cyc_empty",   32'(bus.empty),         32'(q.size() == 0));
         check("cyc_full",    32'(bus.full),          32'(q.size() == DEPTH));
         check("cyc_frame",   32'(frame_err),         32'(m_frame));
         check("cyc_parity",  32'(parity_err),        32'(m_par));
         check("cyc_overrun", 32'(overrun_err),       32'(m_ovr));
      end
   end

   // What one complete frame must do to the FIFO and flags.
   task automatic model_frame(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                              input logic stop);
      int ones;
      logic want;
      if (!stop) begin
         m_frame = 1'b1;
      end else begin
         if (pm == 2'b01 || pm == 2'b10) begin
            ones = $countones(d);
            want = (pm == 2'b01) ? logic'(ones % 2) : logic'(1 - ones % 2);
            if (pbit != want) m_par = 1'b1;
         end
         if (q.size() == DEPTH) m_ovr = 1'b1;
         else begin
            q.push_back(d);
            m_pushes++;
         end
      end
   endtask

   // All line-driving tasks start and end one time unit after a rising edge.
   task automatic drive_bit(input logic v, input int div);
      rx = v;
      repeat (div) @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [7:0] d, input logic pbit, input logic stop,
                        input int div, input int low_bits);
      chk_en = 1'b0;
      drive_bit(1'b0, div);
      for (int i = 0; i < DB; i++) drive_bit(d[i], div);
      if (parity_mode == 2'b01 || parity_mode == 2'b10) drive_bit(pbit, div);
      drive_bit(stop, div);
      if (!stop) drive_bit(1'b0, low_bits * div);
      drive_bit(1'b1, 2 * div);
      model_frame(d, parity_mode, pbit, stop);
      check("inbound_pulses", 32'(inb_cnt), 32'(m_pushes));
      chk_en = 1'b1;
   endtask

   task automatic set_div(input int v);
      speed = DW'(v);
      set_speed = 1'b1;
      @(posedge clk); #1;
      set_speed = 1'b0;
   endtask

   task automatic pop_expect(input logic [7:0] exp);
      check("pop_head", 32'(bus.data_received), 32'(exp));
      bus.rd_en = 1'b1;
      @(posedge clk);
      if (q.size() > 0) void'(q.pop_front());
      #1;
      bus.rd_en = 1'b0;
   endtask

   task automatic clear();
      clear_err = 1'b1;
      @(posedge clk);
      m_frame = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
      #1;
      clear_err = 1'b0;
   endtask

   initial begin
      reset = 1'b0; rx = 1'b1; speed = '0; set_speed = 1'b0;
      parity_mode = 2'b00; clear_err = 1'b0; bus.rd_en = 1'b0;
      m_frame = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("rst_empty",   32'(bus.empty),         32'd1);
      check("rst_count",   32'(bus.count),         32'd0);
      check("rst_data",    32'(bus.data_received), 32'd0);
      check("rst_full",    32'(bus.full),          32'd0);
      check("rst_inbound", 32'(bus.uart_inbound),  32'd0);
      check("rst_errs",    {29'd0, frame_err, parity_err, overrun_err}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;

      // basic 8N1 at div 16
      set_div(16);
      frame(8'hA5, 1'b0, 1'b1, 16, 0);
      check("a5_data",  32'(bus.data_received), 32'h0A5);
      check("a5_count", 32'(bus.count),         32'd1);
      check("a5_pulse", 32'(inb_cnt),           32'd1);
      check("a5_errs",  {29'd0, frame_err, parity_err, overrun_err}, 32'd0);
      pop_expect(8'hA5);

      // even parity, wrong parity bit: byte still pushed
      parity_mode = 2'b01;
      frame(8'h03, 1'b1, 1'b1, 16, 0);
      check("par_err_set", 32'(parity_err),        32'd1);
      check("par_data",    32'(bus.data_received), 32'h003);
      clear();
      check("par_err_clr", 32'(parity_err),        32'd0);
      pop_expect(8'h03);

      // odd parity, matching parity bit
      parity_mode = 2'b10;
      frame(8'h03, 1'b1, 1'b1, 16, 0);
      check("odd_ok", 32'(parity_err), 32'd0);
      pop_expect(8'h03);
      parity_mode = 2'b00;

      // fill past depth: fifth byte lost
      for (int i = 1; i <= 5; i++) frame(8'(i * 8'h11), 1'b0, 1'b1, 16, 0);
      check("ovr_full", 32'(bus.full),          32'd1);
      check("ovr_head", 32'(bus.data_received), 32'h011);
      check("ovr_flag", 32'(overrun_err),       32'd1);
      check("ovr_cnt",  32'(bus.count),         32'd4);
      for (int i = 1; i <= 4; i++) pop_expect(8'(i * 8'h11));
      check("ovr_empty", 32'(bus.empty), 32'd1);
      clear();

      // bad stop bit then a long break, then a clean frame
      frame(8'h3C, 1'b0, 1'b0, 16, 40);
      check("brk_frame", 32'(frame_err), 32'd1);
      check("brk_count", 32'(bus.count), 32'd0);
      frame(8'h7E, 1'b0, 1'b1, 16, 0);
      check("brk_next", 32'(bus.data_received), 32'h07E);
      pop_expect(8'h7E);
      clear();

      // short glitch at div 64 is a false start
      set_div(64);
      chk_en = 1'b0;
      rx = 1'b0;
      repeat (16) @(posedge clk); #1;
      rx = 1'b1;
      repeat (3 * 64) @(posedge clk); #1;
      chk_en = 1'b1;
      check("glitch_count", 32'(bus.count), 32'd0);
      check("glitch_pulse", 32'(inb_cnt),   32'(m_pushes));
      check("glitch_errs",  {29'd0, frame_err, parity_err, overrun_err}, 32'd0);

      // speed change during a frame only affects the next frame
      set_div(16);
      fork
         frame(8'h5A, 1'b0, 1'b1, 16, 0);
         begin
            repeat (40) @(posedge clk); #1;
            set_div(32);
         end
      join
      check("spd_old", 32'(bus.data_received), 32'h05A);
      frame(8'hC3, 1'b0, 1'b1, 32, 0);
      check("spd_new_cnt", 32'(bus.count), 32'd2);
      pop_expect(8'h5A);
      pop_expect(8'hC3);

      // reset in the middle of a frame
      frame(8'h99, 1'b0, 1'b1, 32, 0);
      check("pre_rst_cnt", 32'(bus.count), 32'd1);
      chk_en = 1'b0;
      drive_bit(1'b0, 32);
      drive_bit(1'b1, 32);
      drive_bit(1'b0, 32);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_empty", 32'(bus.empty), 32'd1);
      check("mid_rst_count", 32'(bus.count), 32'd0);
      check("mid_rst_data",  32'(bus.data_received), 32'd0);
      q.delete();
      m_frame = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
      rx = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      chk_en = 1'b1;
      repeat (8) @(posedge clk); #1;
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
